branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the ID-stage branch comparator.
- Resolves MIPS32 conditional branches (beq/bne/blez/bgtz/bgez/bltz) over DATA_WIDTH operands.
- Adds a dynamic direction predictor: table of 2-bit saturating counters, selectable static, bimodal or gshare indexing.
- Read port serves IF; resolve port sits in ID, raises same-cycle mispredict for the pipeline flush and trains the table at the clock edge.

Parameters:
- DATA_WIDTH, 32, comparator operand width (>=2).
- IDX_BITS, 6, log2 of predictor table depth (64 entries).
- HIST_BITS, 6, global history length for gshare (<= IDX_BITS).
- PRED_MODE, 1, 0 = static not-taken, 1 = bimodal, 2 = gshare.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch PC for lookup.
- if_pred_taken  out  1  predicted direction for if_pc.
- res_valid  in  1  a branch is being resolved this cycle.
- res_pc  in  32  PC of resolving branch.
- res_pred_taken  in  1  prediction carried down the pipe with the branch.
- input_1  in  DATA_WIDTH  rs operand (forwarded).
- input_2  in  DATA_WIDTH  rt operand (forwarded).
- BranchOp  in  3  branch opcode class.
- flag  in  5  rt field for REGIMM.
- branch_taken  out  1  actual outcome.
- mispredict  out  1  outcome differs from res_pred_taken.
- branch_cnt  out  32  resolved-branch count (optional feature).
- mispredict_cnt  out  32  mispredict count (optional feature).

Behaviour:
- Reset is asynchronous, active-low (rst_n).
  - All counters go to 2'b01 (weakly not-taken); GHR to 0; perf counters to 0.
- Comparator (combinational, DATA_WIDTH-generic):
  - 4 beq: input_1 == input_2.
  - 5 bne: input_1 != input_2.
  - 6 blez: sign bit set, or input_1 == 0.
  - 7 bgtz: sign bit clear and input_1 != 0.
  - 1 REGIMM: flag == 5'b00001 gives bgez (sign clear); flag == 5'b00000 gives bltz (sign set); any other flag gives 0.
  - Any other BranchOp: 0, and not a branch.
- is_br = res_valid & BranchOp in {1,4,5,6,7}.
- branch_taken = is_br & outcome; mispredict = is_br & (branch_taken != res_pred_taken).
- Both outputs are combinational, zero latency.
- Index: bimodal uses pc[IDX_BITS+1:2]. Gshare uses the same bits XOR {zero-pad, GHR}. The lookup uses the current GHR; the resolve index uses the current GHR at resolve time.
- if_pred_taken = counter[idx][1], combinational. PRED_MODE 0 forces 0 and disables table writes.
- Update on rising clk when is_br:
  - Taken: counter saturating increment (3 stays 3).
  - Not taken: saturating decrement (0 stays 0).
  - Gshare only: GHR <= {GHR[HIST_BITS-2:0], branch_taken}.
- Same-cycle lookup and update to the same index: lookup returns the pre-update value (no bypass).
- res_valid with a non-branch BranchOp: no update, no mispredict.
- Reset asserted mid-operation: table, GHR and counters clear immediately. Outputs reflect the reset table while rst_n is low.

Optional Feature:
- BP_PERF_CNT_EN defined:
  - branch_cnt increments on every is_br cycle.
  - mispredict_cnt increments on every mispredict cycle.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: no counter flops; both outputs tied to 0.

Test Plan:
- Reset, then if_pc = 0x400000 → if_pred_taken = 0. Resolve beq 5/5 at the same PC with res_pred_taken = 0 → branch_taken = 1, mispredict = 1. Next cycle if_pred_taken = 1 (counter 2).
- Bimodal saturation: 4 taken resolves on one PC → counter 3. One not-taken → still predicts taken. Second not-taken → predicts not-taken.
- Comparator sweep:
  - bgtz input_1 = 0 → 0; = 1 → 1; = 0x80000000 → 0.
  - blez 0 → 1.
  - REGIMM flag = 1, input_1 = 0xFFFFFFFF → 0; flag = 0 same operand → 1; flag = 0x11 → 0.
- Gshare (PRED_MODE = 2): alternating T/NT branch at a single PC, 20 resolves → mispredict low after warm-up (history disambiguates). Bimodal run on the same pattern → mispredicts persist.
- Async reset: drive rst_n low between clock edges after training → if_pred_taken drops to 0 without a clock edge. With BP_PERF_CNT_EN, counters read 0.
- BP_PERF_CNT_EN: 10 branches with 3 mispredicts → branch_cnt = 10, mispredict_cnt = 3. res_valid with BranchOp = 0 → no change.

Source files
------------

// File: rtl/branch_predict_unit.sv
// ID-stage MIPS32 branch resolver with a 2-bit counter direction predictor (static/bimodal/gshare).
// Define BP_PERF_CNT_EN to build the saturating branch/mispredict performance counters.
module branch_predict_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_BITS   = 6,
  parameter int HIST_BITS  = 6,
  parameter int PRED_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           if_pc,
  output logic                  if_pred_taken,
  input  logic                  res_valid,
  input  logic [31:0]           res_pc,
  input  logic                  res_pred_taken,
  input  logic [DATA_WIDTH-1:0] input_1,
  input  logic [DATA_WIDTH-1:0] input_2,
  input  logic [2:0]            BranchOp,
  input  logic [4:0]            flag,
  output logic                  branch_taken,
  output logic                  mispredict,
  output logic [31:0]           branch_cnt,
  output logic [31:0]           mispredict_cnt
);

  localparam int         DEPTH = 1 << IDX_BITS;
  localparam logic [1:0] MODE  = PRED_MODE[1:0];

  logic [1:0]           ctr_r [DEPTH];
  logic [HIST_BITS-1:0] ghr_r;
  logic                 outcome_s;
  logic                 is_op_s;
  logic                 is_br_s;
  logic                 sign_s;
  logic                 zero_s;
  logic [IDX_BITS-1:0]  if_idx_s;
  logic [IDX_BITS-1:0]  res_idx_s;

  function automatic logic [IDX_BITS-1:0] table_index(input logic [31:0] pc,
                                                       input logic [HIST_BITS-1:0] ghr);
    logic [IDX_BITS-1:0] base;
    base = pc[IDX_BITS+1:2];
    if (MODE == 2'd2) begin
      return base ^ IDX_BITS'(ghr);
    end else begin
      return base;
    end
  endfunction

  function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
  endfunction

  assign sign_s = input_1[DATA_WIDTH-1];
  assign zero_s = (input_1 == {DATA_WIDTH{1'b0}});

  // Branch condition evaluation and branch-class decode
  always_comb begin
    outcome_s = 1'b0;
    is_op_s   = 1'b0;
    case (BranchOp)
      3'd4: begin is_op_s = 1'b1; outcome_s = (input_1 == input_2); end
      3'd5: begin is_op_s = 1'b1; outcome_s = (input_1 != input_2); end
      3'd6: begin is_op_s = 1'b1; outcome_s = sign_s | zero_s; end
      3'd7: begin is_op_s = 1'b1; outcome_s = ~sign_s & ~zero_s; end
      3'd1: begin
        is_op_s = 1'b1;
        case (flag)
          5'b00001: outcome_s = ~sign_s;
          5'b00000: outcome_s = sign_s;
          default:  outcome_s = 1'b0;
        endcase
      end
      default: begin is_op_s = 1'b0; outcome_s = 1'b0; end
    endcase
  end

  assign is_br_s       = res_valid & is_op_s;
  assign branch_taken  = is_br_s & outcome_s;
  assign mispredict    = is_br_s & (branch_taken != res_pred_taken);

  assign if_idx_s      = table_index(if_pc, ghr_r);
  assign res_idx_s     = table_index(res_pc, ghr_r);
  // No bypass: a same-cycle update to the looked-up entry shows up next cycle.
  assign if_pred_taken = (MODE == 2'd0) ? 1'b0 : ctr_r[if_idx_s][1];

  // Counter table training on resolved branches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (is_br_s && (MODE != 2'd0)) begin
      ctr_r[res_idx_s] <= sat_step(ctr_r[res_idx_s], branch_taken);
    end
  end

  // Global history shift register, only advanced in gshare mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= {HIST_BITS{1'b0}};
    end else if (is_br_s && (MODE == 2'd2)) begin
      ghr_r <= {ghr_r[HIST_BITS-2:0], branch_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] mispredict_cnt_r;

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_r     <= 32'd0;
      mispredict_cnt_r <= 32'd0;
    end else begin
      if (is_br_s && (branch_cnt_r != 32'hFFFF_FFFF)) begin
        branch_cnt_r <= branch_cnt_r + 32'd1;
      end else begin
        branch_cnt_r <= branch_cnt_r;
      end
      if (mispredict && (mispredict_cnt_r != 32'hFFFF_FFFF)) begin
        mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
      end else begin
        mispredict_cnt_r <= mispredict_cnt_r;
      end
    end
  end

  assign branch_cnt     = branch_cnt_r;
  assign mispredict_cnt = mispredict_cnt_r;
`else
  assign branch_cnt     = 32'd0;
  assign mispredict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: a bimodal and a gshare instance share one stimulus stream.
module tb_branch_predict_unit;

  localparam logic [2:0]  OP_NONE = 3'd0, OP_REGIMM = 3'd1, OP_BEQ = 3'd4, OP_BNE = 3'd5;
  localparam logic [2:0]  OP_BLEZ = 3'd6, OP_BGTZ = 3'd7;
  localparam logic [31:0] PC_A = 32'h0040_0000, PC_B = 32'h0040_0010, PC_S = 32'h0040_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, res_pc, input_1, input_2;
  logic        res_valid, res_pred_taken;
  logic [2:0]  branch_op;
  logic [4:0]  flag;

  logic        pred_b, taken_b, misp_b, pred_g, taken_g, misp_g;
  logic [31:0] bcnt_b, mcnt_b, bcnt_g, mcnt_g;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_br   = 0;
  int exp_mp   = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(.DATA_WIDTH(32), .IDX_BITS(6), .HIST_BITS(6), .PRED_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred_b),
    .res_valid(res_valid), .res_pc(res_pc), .res_pred_taken(res_pred_taken),
    .input_1(input_1), .input_2(input_2), .BranchOp(branch_op), .flag(flag),
    .branch_taken(taken_b), .mispredict(misp_b),
    .branch_cnt(bcnt_b), .mispredict_cnt(mcnt_b));

  branch_predict_unit #(.DATA_WIDTH(32), .IDX_BITS(6), .HIST_BITS(6), .PRED_MODE(2)) dut_g (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred_g),
    .res_valid(res_valid), .res_pc(res_pc), .res_pred_taken(res_pred_taken),
    .input_1(input_1), .input_2(input_2), .BranchOp(branch_op), .flag(flag),
    .branch_taken(taken_g), .mispredict(misp_g),
    .branch_cnt(bcnt_g), .mispredict_cnt(mcnt_g));

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a resolve at the falling edge, check the combinational outputs; training happens at the next rising edge.
  task automatic resolve(input string tag, input logic valid, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] fl,
                         input logic [31:0] pc, input logic pred, input logic exp_t, input logic br);
    logic exp_m;
    @(negedge clk);
    res_valid = valid; branch_op = op; input_1 = a; input_2 = b; flag = fl;
    res_pc = pc; if_pc = pc; res_pred_taken = pred;
    #1;
    exp_m = br & (exp_t != pred);
    chk1({tag, "_taken_b"}, taken_b, exp_t);
    chk1({tag, "_taken_g"}, taken_g, exp_t);
    chk1({tag, "_misp_b"}, misp_b, exp_m);
    chk1({tag, "_misp_g"}, misp_g, exp_m);
    if (br) exp_br++;
    if (exp_m) exp_mp++;
  endtask

  task automatic idle(input logic [31:0] pc);
    @(negedge clk);
    res_valid = 1'b0; branch_op = OP_NONE; if_pc = pc;
    #1;
  endtask

  task automatic chk_counts(input string tag);
`ifdef BP_PERF_CNT_EN
    chk32({tag, "_bcnt_b"}, bcnt_b, 32'(exp_br));
    chk32({tag, "_mcnt_b"}, mcnt_b, 32'(exp_mp));
    chk32({tag, "_bcnt_g"}, bcnt_g, 32'(exp_br));
    chk32({tag, "_mcnt_g"}, mcnt_g, 32'(exp_mp));
`else
    chk32({tag, "_bcnt_b"}, bcnt_b, 32'd0);
    chk32({tag, "_mcnt_b"}, mcnt_b, 32'd0);
    chk32({tag, "_bcnt_g"}, bcnt_g, 32'd0);
    chk32({tag, "_mcnt_g"}, mcnt_g, 32'd0);
`endif
  endtask

  initial begin
    logic outc, exp_g, exp_b;
    rst_n = 1'b0; if_pc = PC_A; res_pc = PC_A; res_valid = 1'b0; res_pred_taken = 1'b0;
    input_1 = 32'd0; input_2 = 32'd0; branch_op = OP_NONE; flag = 5'd0;
    #2;
    chk1("reset_pred_b", pred_b, 1'b0);
    chk1("reset_pred_g", pred_g, 1'b0);
    chk1("reset_taken_b", taken_b, 1'b0);
    chk_counts("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // First branch: beq 5/5, predicted not-taken
    resolve("s1", 1'b1, OP_BEQ, 32'd5, 32'd5, 5'd0, PC_A, 1'b0, 1'b1, 1'b1);
    chk1("s1_pre_b", pred_b, 1'b0);
    chk1("s1_pre_g", pred_g, 1'b0);
    idle(PC_A);
    chk1("s1_post_b", pred_b, 1'b1);
    chk1("s1_post_g", pred_g, 1'b0);

    // Bimodal saturation on PC_B
    repeat (4) resolve("sat_t", 1'b1, OP_BEQ, 32'd7, 32'd7, 5'd0, PC_B, 1'b1, 1'b1, 1'b1);
    idle(PC_B);
    chk1("sat3_b", pred_b, 1'b1);
    resolve("sat_n1", 1'b1, OP_BNE, 32'd7, 32'd7, 5'd0, PC_B, 1'b1, 1'b0, 1'b1);
    chk1("sat_n1_pre_b", pred_b, 1'b1);
    idle(PC_B);
    chk1("sat2_b", pred_b, 1'b1);
    resolve("sat_n2", 1'b1, OP_BNE, 32'd7, 32'd7, 5'd0, PC_B, 1'b1, 1'b0, 1'b1);
    chk1("sat_n2_pre_b", pred_b, 1'b1);
    idle(PC_B);
    chk1("sat1_b", pred_b, 1'b0);

    // Comparator sweep
    resolve("bgtz_0",   1'b1, OP_BGTZ,   32'h0000_0000, 32'd0, 5'd0,  PC_S, 1'b0, 1'b0, 1'b1);
    resolve("bgtz_1",   1'b1, OP_BGTZ,   32'h0000_0001, 32'd0, 5'd0,  PC_S, 1'b0, 1'b1, 1'b1);
    resolve("bgtz_neg", 1'b1, OP_BGTZ,   32'h8000_0000, 32'd0, 5'd0,  PC_S, 1'b0, 1'b0, 1'b1);
    resolve("blez_0",   1'b1, OP_BLEZ,   32'h0000_0000, 32'd0, 5'd0,  PC_S, 1'b0, 1'b1, 1'b1);
    resolve("bgez_neg", 1'b1, OP_REGIMM, 32'hFFFF_FFFF, 32'd0, 5'h01, PC_S, 1'b0, 1'b0, 1'b1);
    resolve("bltz_neg", 1'b1, OP_REGIMM, 32'hFFFF_FFFF, 32'd0, 5'h00, PC_S, 1'b0, 1'b1, 1'b1);
    resolve("regimm_x", 1'b1, OP_REGIMM, 32'hFFFF_FFFF, 32'd0, 5'h11, PC_S, 1'b0, 1'b0, 1'b1);
    resolve("bne_ne",   1'b1, OP_BNE,    32'd3,         32'd4, 5'd0,  PC_S, 1'b0, 1'b1, 1'b1);
    resolve("beq_ne",   1'b1, OP_BEQ,    32'd3,         32'd4, 5'd0,  PC_S, 1'b0, 1'b0, 1'b1);
    // Non-branch opcodes and an invalid slot must neither count nor mispredict
    resolve("op0",      1'b1, OP_NONE,   32'd9,         32'd9, 5'd0,  PC_S, 1'b1, 1'b0, 1'b0);
    resolve("op3",      1'b1, 3'd3,      32'd9,         32'd9, 5'd0,  PC_S, 1'b1, 1'b0, 1'b0);
    resolve("novalid",  1'b0, OP_BEQ,    32'd9,         32'd9, 5'd0,  PC_S, 1'b1, 1'b0, 1'b0);
    idle(PC_A);
    chk_counts("phase1");
    chk1("pre_rst_b", pred_b, 1'b1);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_pred_b", pred_b, 1'b0);
    chk1("async_pred_g", pred_g, 1'b0);
    exp_br = 0;
    exp_mp = 0;
    chk_counts("async");
    @(negedge clk);
    rst_n = 1'b1;

    // Alternating T/NT at one PC: gshare locks on after warm-up, bimodal always wrong
    for (int k = 1; k <= 20; k++) begin
      outc  = (k % 2 == 1);
      exp_g = (k <= 7) ? 1'b0 : outc;
      exp_b = (k % 2 == 0);
      resolve($sformatf("alt%0d", k), 1'b1, OP_BEQ, 32'd1, outc ? 32'd1 : 32'd2, 5'd0,
              PC_A, exp_g, outc, 1'b1);
      chk1($sformatf("alt%0d_pred_g", k), pred_g, exp_g);
      chk1($sformatf("alt%0d_pred_b", k), pred_b, exp_b);
    end
    idle(PC_A);
    chk_counts("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
